mem_instr_sequencer: RTL

MEM_INSTR_SEQUENCER -- requirements
Module: mem_instr_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 121 ++++++++++++
 rtl/mem_wait_counter.sv | 36 +++
 rtl/mem_instr_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the instruction sequencer: state encoding,
// opcode constants, strobe bundle and the Moore strobe decode.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    OP_LD,
    OP_LDI,
    OP_ST,
    OP_BAD
  } op_kind_t;

  localparam int LD  = 0;
  localparam int LDI = 1;
  localparam int ST  = 2;

  localparam logic [4:0] ALU_ADD = 5'b00000;

  typedef struct packed {
    logic       pc_select;
    logic       mar_enable;
    logic       pc_inc;
    logic       read;
    logic       mdr_enable;
    logic       mdr_select;
    logic       ir_enable;
    logic       gra;
    logic       grb;
    logic       ba_select;
    logic       r_enable;
    logic       r_out;
    logic       y_enable;
    logic       c_select;
    logic       z_enable;
    logic       z_lo_select;
    logic       write;
    logic       done;
    logic [4:0] alu;
  } strobes_t;

  // enter: first cycle of the step; last: final cycle of a wait step.
  function automatic strobes_t decode(
    state_t   s,
    op_kind_t k,
    logic     enter,
    logic     last
  );
    strobes_t o;
    o = '0;
    unique case (s)
      S_T0: begin
        o.pc_select  = 1'b1;
        o.mar_enable = 1'b1;
      end
      S_T1: begin
        o.pc_inc     = enter;
        o.read       = 1'b1;
        o.mdr_enable = 1'b1;
      end
      S_T2: begin
        o.mdr_select = 1'b1;
        o.ir_enable  = 1'b1;
      end
      S_T3: begin
        o.grb       = 1'b1;
        o.ba_select = 1'b1;
        o.y_enable  = 1'b1;
      end
      S_T4: begin
        o.c_select = 1'b1;
        o.z_enable = 1'b1;
        o.alu      = ALU_ADD;
      end
      S_T5: begin
        o.z_lo_select = 1'b1;
        if (k == OP_LDI) begin
          o.gra      = 1'b1;
          o.r_enable = 1'b1;
          o.done     = 1'b1;
        end else begin
          o.mar_enable = 1'b1;
        end
      end
      S_T6: begin
        o.mdr_enable = 1'b1;
        if (k == OP_ST) begin
          o.gra   = 1'b1;
          o.r_out = 1'b1;
        end else begin
          o.read = 1'b1;
        end
      end
      S_T7: begin
        if (k == OP_ST) begin
          o.write = 1'b1;
          o.done  = last;
        end else begin
          o.mdr_select = 1'b1;
          o.gra        = 1'b1;
          o.r_enable   = 1'b1;
          o.done       = 1'b1;
        end
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// 4-bit memory wait counter: load, saturating decrement, zero flags.
// Ports: clk, reset, load, dec, load_val -> zero (now), zero_nxt (next).
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero,
  output logic       zero_nxt
);

  logic [3:0] cnt;
  logic [3:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (load) begin
      cnt_n = load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt_n = cnt - 4'd1;
    end
  end

  assign zero     = (cnt == 4'd0);
  assign zero_nxt = (cnt_n == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/mem_instr_sequencer.sv
// Multi-cycle ld/ldi/st control sequencer with registered Moore strobes.
// Ports: clk, reset, run, IR_Data -> datapath strobes, alu_instruction,
// done, illegal. Define STORE_EN to make the st opcode legal.
module mem_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int OPC_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] IR_Data,
  output logic        PC_select,
  output logic        MAR_enable,
  output logic        PC_increment_enable,
  output logic        read,
  output logic        MDR_enable,
  output logic        MDR_select,
  output logic        IR_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        ba_select,
  output logic        r_enable,
  output logic        r_out,
  output logic        Y_enable,
  output logic        c_select,
  output logic        Z_enable,
  output logic        Z_LO_select,
  output logic        write,
  output logic [4:0]  alu_instruction,
  output logic        done,
  output logic        illegal
);

  state_t     state;
  state_t     state_n;
  op_kind_t   kind;
  op_kind_t   kind_n;
  op_kind_t   kind_in;
  strobes_t   so;
  logic [OPC_W-1:0] opc;
  logic       enter;
  logic       load;
  logic       zero;
  logic       zero_nxt;

  assign opc = IR_Data[31:32-OPC_W];

  always_comb begin
    kind_in = OP_BAD;
    unique case (1'b1)
      (opc == OPC_W'(LD)):  kind_in = OP_LD;
      (opc == OPC_W'(LDI)): kind_in = OP_LDI;
`ifdef STORE_EN
      (opc == OPC_W'(ST)):  kind_in = OP_ST;
`endif
      default: kind_in = OP_BAD;
    endcase
  end

  always_comb begin
    state_n = state;
    kind_n  = kind;
    unique case (state)
      S_IDLE: if (run) state_n = S_T0;
      S_T0:   state_n = S_T1;
      S_T1:   if (zero) state_n = S_T2;
      S_T2:   state_n = S_T3;
      S_T3: begin
        kind_n  = kind_in;
        state_n = (kind_in == OP_BAD) ? S_HALT : S_T4;
      end
      S_T4:   state_n = S_T5;
      S_T5: begin
        if (kind == OP_LDI) begin
          state_n = run ? S_T0 : S_IDLE;
        end else begin
          state_n = S_T6;
        end
      end
      S_T6: begin
        if (kind == OP_ST || zero) state_n = S_T7;
      end
      S_T7: begin
        if (kind != OP_ST || zero) begin
          state_n = run ? S_T0 : S_IDLE;
        end
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  // Counter is armed on the edge that enters a wait-capable step.
  assign enter = (state_n != state);
  assign load  = enter &&
                 (state_n == S_T1 ||
                  (state_n == S_T6 && kind_n == OP_LD) ||
                  (state_n == S_T7 && kind_n == OP_ST));

  mem_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (~load),
    .load_val (4'(MEM_WAIT)),
    .zero     (zero),
    .zero_nxt (zero_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      kind    <= OP_LD;
      so      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      kind  <= kind_n;
      so    <= decode(state_n, kind_n, enter, zero_nxt);
      if (state_n == S_HALT) illegal <= 1'b1;
    end
  end

  assign PC_select           = so.pc_select;
  assign MAR_enable          = so.mar_enable;
  assign PC_increment_enable = so.pc_inc;
  assign read                = so.read;
  assign MDR_enable          = so.mdr_enable;
  assign MDR_select          = so.mdr_select;
  assign IR_enable           = so.ir_enable;
  assign Gra                 = so.gra;
  assign Grb                 = so.grb;
  assign ba_select           = so.ba_select;
  assign r_enable            = so.r_enable;
  assign Y_enable            = so.y_enable;
  assign c_select            = so.c_select;
  assign Z_enable            = so.z_enable;
  assign Z_LO_select         = so.z_lo_select;
  assign alu_instruction     = so.alu;
  assign done                = so.done;

  logic unused_bits;
`ifdef STORE_EN
  assign r_out       = so.r_out;
  assign write       = so.write;
  assign unused_bits = ^IR_Data[31-OPC_W:0];
`else
  assign r_out       = 1'b0;
  assign write       = 1'b0;
  assign unused_bits = ^{IR_Data[31-OPC_W:0], so.r_out, so.write};
`endif

endmodule
